// File: rtl/ps2_player_key_router.sv
// Routes PS/2 scan codes to per-player arrow-event FIFOs through a keymap.
// Two stages: prefix parse plus keymap match, then held-state update and enqueue.
module ps2_player_key_router #(
    parameter int NUM_PLAYERS     = 2,
    parameter int FIFO_DEPTH      = 4,
    parameter int REPEAT_SUPPRESS = 1,
    parameter logic [NUM_PLAYERS*36-1:0] KEYMAP = {9'h174, 9'h172, 9'h16B, 9'h175,
                                                   9'h023, 9'h01B, 9'h01C, 9'h01D}
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic [7:0]               ps2_byte,
    input  logic                     ps2_byte_valid,
    output logic [NUM_PLAYERS-1:0]   evt_valid,
    output logic [3*NUM_PLAYERS-1:0] evt_code,
    input  logic [NUM_PLAYERS-1:0]   evt_ready,
    output logic [4*NUM_PLAYERS-1:0] held,
    output logic [NUM_PLAYERS-1:0]   overflow,
    input  logic [NUM_PLAYERS-1:0]   ovf_clear,
    output logic [1:0]               parse_state
);

    localparam int NE = 4 * NUM_PLAYERS;
    localparam int IW = $clog2(NE);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0]   FULL_CNT = (PW+1)'(FIFO_DEPTH);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    state_t          state;
    logic            dec_valid;
    logic            dec_make;
    logic [8:0]      dec_key;
    logic            match_hit;
    logic [IW-1:0]   match_idx;
    logic            s1_hit;
    logic            s1_make;
    logic [IW-1:0]   s1_idx;
    logic [31:0]     s1_player;
    logic [2:0]      s1_kcode;
    logic            enq;

    assign parse_state = state;

    // Decode the byte against the current prefix state into a {ext,code} event.
    always_comb begin
        dec_valid = 1'b0;
        dec_make  = 1'b1;
        dec_key   = 9'h000;
        if (ps2_byte_valid) begin
            unique case (state)
                IDLE: begin
                    if (ps2_byte != 8'hE0 && ps2_byte != 8'hF0 && ps2_byte != 8'hE1) begin
                        dec_valid = 1'b1;
                        dec_key   = {1'b0, ps2_byte};
                    end
                end
                EXT: begin
                    if (ps2_byte != 8'hF0 && ps2_byte != 8'hE0) begin
                        dec_valid = 1'b1;
                        dec_key   = {1'b1, ps2_byte};
                    end
                end
                BRK: begin
                    dec_valid = 1'b1;
                    dec_make  = 1'b0;
                    dec_key   = {1'b0, ps2_byte};
                end
                EXT_BRK: begin
                    dec_valid = 1'b1;
                    dec_make  = 1'b0;
                    dec_key   = {1'b1, ps2_byte};
                end
            endcase
        end
    end

    // Scan from the top so the lowest matching entry is the one left standing.
    always_comb begin
        match_hit = 1'b0;
        match_idx = '0;
        for (int e = NE - 1; e >= 0; e--) begin
            if (dec_valid && KEYMAP[9*e +: 9] == dec_key) begin
                match_hit = 1'b1;
                match_idx = e[IW-1:0];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state   <= IDLE;
            s1_hit  <= 1'b0;
            s1_make <= 1'b0;
            s1_idx  <= '0;
        end else begin
            s1_hit  <= match_hit;
            s1_make <= dec_make;
            s1_idx  <= match_idx;
            if (ps2_byte_valid) begin
                unique case (state)
                    IDLE: begin
                        if (ps2_byte == 8'hE0)      state <= EXT;
                        else if (ps2_byte == 8'hF0) state <= BRK;
                        else                        state <= IDLE;
                    end
                    EXT: begin
                        if (ps2_byte == 8'hF0)      state <= EXT_BRK;
                        else if (ps2_byte == 8'hE0) state <= EXT;
                        else                        state <= IDLE;
                    end
                    BRK:     state <= IDLE;
                    EXT_BRK: state <= IDLE;
                endcase
            end
        end
    end

    assign s1_player = 32'(s1_idx) >> 2;
    assign s1_kcode  = {1'b0, s1_idx[1:0]} + 3'd1;
    assign enq       = s1_hit && s1_make && !(REPEAT_SUPPRESS != 0 && held[s1_idx]);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            held <= '0;
        end else if (s1_hit) begin
            held[s1_idx] <= s1_make;
        end
    end

    // Handshake: evt_valid[p] is high while FIFO p holds an entry and evt_code
    // shows its head; an entry is consumed on any edge where evt_valid[p] and
    // evt_ready[p] are both high, and the next entry appears the cycle after.
    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        logic [2:0]    mem [FIFO_DEPTH];
        logic [PW-1:0] wr_ptr;
        logic [PW-1:0] rd_ptr;
        logic [PW:0]   count;
        logic          push;
        logic          pop;
        logic          full;
        logic          do_push;
        logic          ovf_r;

        assign push    = enq && (s1_player == 32'(p));
        assign pop     = (count != '0) && evt_ready[p];
        assign full    = (count == FULL_CNT);
        assign do_push = push && (!full || pop);

        always_ff @(posedge clock) begin
            if (!resetn) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
                ovf_r  <= 1'b0;
            end else begin
                if (do_push) begin
                    mem[wr_ptr] <= s1_kcode;
                    wr_ptr      <= wr_ptr + PTR_ONE;
                end
                if (pop) rd_ptr <= rd_ptr + PTR_ONE;
                unique case ({do_push, pop})
                    2'b10:   count <= count + CNT_ONE;
                    2'b01:   count <= count - CNT_ONE;
                    default: count <= count;
                endcase
                // A new drop outranks a clear arriving in the same cycle.
                if (push && full && !pop) ovf_r <= 1'b1;
                else if (ovf_clear[p])    ovf_r <= 1'b0;
            end
        end

        assign evt_valid[p]      = (count != '0);
        assign evt_code[3*p +: 3] = (count != '0) ? mem[rd_ptr] : 3'b000;
        assign overflow[p]       = ovf_r;
    end

endmodule
